crossbar_2x2_sched: RTL and testbench

//  Input stage directly upstream of the 2x2 4-bit crossbar. Buffers two tagged input streams in per-port FIFOs.

---
 rtl/crossbar_2x2_sched.sv | 123 ++++++++++++
 tb/tb_crossbar_2x2_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/crossbar_2x2_sched.sv
// ============================================================================
// Module   : crossbar_2x2_sched
// Purpose  : Input scheduler for a 2x2 crossbar. It has two tagged FIFOs and
//            round-robin conflict resolution. in1/in2/control are registered.
// Options  : XBAR_SCHED_STATS_EN adds a saturating conflict counter port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crossbar_2x2_sched #(
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] a_data,
  input  logic          a_dest,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [DW-1:0] b_data,
  input  logic          b_dest,
  input  logic          out1_ready,
  input  logic          out2_ready,
  output logic [DW-1:0] xbar_in1,
  output logic [DW-1:0] xbar_in2,
  output logic          xbar_control,
  output logic          out1_valid,
  output logic          out2_valid
`ifdef XBAR_SCHED_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam int   c_aw     = $clog2(DEPTH);
  localparam logic c_prio_a = 1'b0;

  logic [DW:0]   r_mem_a [DEPTH];
  logic [DW:0]   r_mem_b [DEPTH];
  logic [c_aw:0] r_wr_a, r_rd_a, r_wr_b, r_rd_b;
  logic          r_prio;

  logic          w_full_a, w_full_b, w_empty_a, w_empty_b;
  logic          w_push_a, w_push_b;
  logic [DW:0]   w_head_a, w_head_b;
  logic          w_elig_a, w_elig_b, w_conflict;
  logic          w_grant_a, w_grant_b;
  logic          w_ctrl_nxt;

  assign w_full_a  = (r_wr_a[c_aw] != r_rd_a[c_aw]) && (r_wr_a[c_aw-1:0] == r_rd_a[c_aw-1:0]);
  assign w_full_b  = (r_wr_b[c_aw] != r_rd_b[c_aw]) && (r_wr_b[c_aw-1:0] == r_rd_b[c_aw-1:0]);
  assign w_empty_a = (r_wr_a == r_rd_a);
  assign w_empty_b = (r_wr_b == r_rd_b);

  // Ready depends only on fullness, so a full FIFO refuses a push even while popping.
  assign a_ready  = !w_full_a;
  assign b_ready  = !w_full_b;
  assign w_push_a = a_valid && !w_full_a;
  assign w_push_b = b_valid && !w_full_b;

  assign w_head_a = r_mem_a[r_rd_a[c_aw-1:0]];
  assign w_head_b = r_mem_b[r_rd_b[c_aw-1:0]];

  assign w_elig_a   = !w_empty_a && (w_head_a[DW] ? out2_ready : out1_ready);
  assign w_elig_b   = !w_empty_b && (w_head_b[DW] ? out2_ready : out1_ready);
  assign w_conflict = w_elig_a && w_elig_b && (w_head_a[DW] == w_head_b[DW]);
  assign w_grant_a  = w_elig_a && (!w_conflict || (r_prio == c_prio_a));
  assign w_grant_b  = w_elig_b && (!w_conflict || (r_prio != c_prio_a));

  always_comb begin
    w_ctrl_nxt = xbar_control;
    if (w_grant_a)      w_ctrl_nxt = w_head_a[DW];
    else if (w_grant_b) w_ctrl_nxt = !w_head_b[DW];
  end

  always_ff @(posedge clk) begin
    if (w_push_a) r_mem_a[r_wr_a[c_aw-1:0]] <= {a_dest, a_data};
    if (w_push_b) r_mem_b[r_wr_b[c_aw-1:0]] <= {b_dest, b_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_a       <= '0;
      r_rd_a       <= '0;
      r_wr_b       <= '0;
      r_rd_b       <= '0;
      r_prio       <= c_prio_a;
      xbar_in1     <= '0;
      xbar_in2     <= '0;
      xbar_control <= 1'b0;
      out1_valid   <= 1'b0;
      out2_valid   <= 1'b0;
    end else begin
      if (w_push_a)  r_wr_a <= r_wr_a + 1'b1;
      if (w_push_b)  r_wr_b <= r_wr_b + 1'b1;
      if (w_grant_a) begin
        r_rd_a   <= r_rd_a + 1'b1;
        xbar_in1 <= w_head_a[DW-1:0];
      end
      if (w_grant_b) begin
        r_rd_b   <= r_rd_b + 1'b1;
        xbar_in2 <= w_head_b[DW-1:0];
      end
      // The winner of a conflict hands priority to the loser.
      if (w_conflict) r_prio <= !r_prio;
      xbar_control <= w_ctrl_nxt;
      out1_valid   <= (w_grant_a && !w_head_a[DW]) || (w_grant_b && !w_head_b[DW]);
      out2_valid   <= (w_grant_a &&  w_head_a[DW]) || (w_grant_b &&  w_head_b[DW]);
    end
  end

`ifdef XBAR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 conflict_cnt <= '0;
    else if (w_conflict && conflict_cnt != '1)  conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_crossbar_2x2_sched.sv
// ============================================================================
// Module   : tb_crossbar_2x2_sched
// Purpose  : Directed self-checking bench for crossbar_2x2_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crossbar_2x2_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_dest, b_valid, b_dest;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready;
  logic       out1_ready, out2_ready;
  logic [3:0] xbar_in1, xbar_in2;
  logic       xbar_control, out1_valid, out2_valid;
  logic [15:0] conflict_cnt;
  int         n_vec = 0;
  int         n_err = 0;

  crossbar_2x2_sched #(.DW(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_dest(a_dest),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_dest(b_dest),
    .out1_ready(out1_ready), .out2_ready(out2_ready),
    .xbar_in1(xbar_in1), .xbar_in2(xbar_in2), .xbar_control(xbar_control),
    .out1_valid(out1_valid), .out2_valid(out2_valid)
`ifdef XBAR_SCHED_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

`ifndef XBAR_SCHED_STATS_EN
  assign conflict_cnt = 16'h0;
`endif

  always #5 clk = ~clk;

  // Crossbar model: control=0 straight, control=1 swap.
  logic [3:0] w_out1, w_out2;
  assign w_out1 = xbar_control ? xbar_in2 : xbar_in1;
  assign w_out2 = xbar_control ? xbar_in1 : xbar_in2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    a_valid = 1'b0; a_data = 4'h0; a_dest = 1'b0;
    b_valid = 1'b0; b_data = 4'h0; b_dest = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_in1"},  {28'h0, xbar_in1}, 32'h0);
    check({tag, "_in2"},  {28'h0, xbar_in2}, 32'h0);
    check({tag, "_ctrl"}, {31'h0, xbar_control}, 32'h0);
    check({tag, "_v"},    {30'h0, out1_valid, out2_valid}, 32'h0);
    check({tag, "_rdy"},  {30'h0, a_ready, b_ready}, 32'h3);
  endtask

  initial begin
    idle_in();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    do_reset();
    check_zero_outs("rst");

    // Disjoint destinations: both words traverse together via swap.
    a_valid = 1'b1; a_data = 4'h3; a_dest = 1'b1;
    b_valid = 1'b1; b_data = 4'h5; b_dest = 1'b0;
    step();
    idle_in();
    step();
    check("disj_ctrl", {31'h0, xbar_control}, 32'h1);
    check("disj_out2", {28'h0, w_out2}, 32'h3);
    check("disj_out1", {28'h0, w_out1}, 32'h5);
    check("disj_v",    {30'h0, out1_valid, out2_valid}, 32'h3);
    step();
    check("disj_done", {30'h0, out1_valid, out2_valid}, 32'h0);

    // Same destination: A wins first, B follows through the swap path.
    a_valid = 1'b1; a_data = 4'hA; a_dest = 1'b0;
    b_valid = 1'b1; b_data = 4'hB; b_dest = 1'b0;
    step();
    idle_in();
    step();
    check("conf1_v",    {30'h0, out1_valid, out2_valid}, 32'h2);
    check("conf1_out1", {28'h0, w_out1}, 32'hA);
    step();
    check("conf2_v",    {30'h0, out1_valid, out2_valid}, 32'h2);
    check("conf2_out1", {28'h0, w_out1}, 32'hB);
    check("conf2_ctrl", {31'h0, xbar_control}, 32'h1);
`ifdef XBAR_SCHED_STATS_EN
    check("conf_cnt", {16'h0, conflict_cnt}, 32'h1);
`endif
    step();
    check("conf_done", {30'h0, out1_valid, out2_valid}, 32'h0);

    // Reset while words are buffered: everything clears immediately.
    out1_ready = 1'b0; out2_ready = 1'b0;
    a_valid = 1'b1; a_data = 4'h7; a_dest = 1'b1;
    b_valid = 1'b1; b_data = 4'h9; b_dest = 1'b0;
    step();
    step();
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    check_zero_outs("mid_rst");
`ifdef XBAR_SCHED_STATS_EN
    check("mid_rst_cnt", {16'h0, conflict_cnt}, 32'h0);
`endif
    step();
    rst_n = 1'b1;
    out1_ready = 1'b1; out2_ready = 1'b1;
    step();
    step();
    check("post_rst_v", {30'h0, out1_valid, out2_valid}, 32'h0);
    check("post_rst_rdy", {30'h0, a_ready, b_ready}, 32'h3);

    // Sustained conflict from a fresh reset: A1 B1 A2 B2 on out1.
    do_reset();
    a_valid = 1'b1; a_data = 4'h1; a_dest = 1'b0;
    b_valid = 1'b1; b_data = 4'h2; b_dest = 1'b0;
    step();
    a_data = 4'h3; b_data = 4'h4;
    step();
    idle_in();
    check("alt0", {27'h0, out1_valid, w_out1}, 32'h11);
    step();
    check("alt1", {27'h0, out1_valid, w_out1}, 32'h12);
    step();
    check("alt2", {27'h0, out1_valid, w_out1}, 32'h13);
    step();
    check("alt3", {27'h0, out1_valid, w_out1}, 32'h14);
`ifdef XBAR_SCHED_STATS_EN
    check("alt_cnt", {16'h0, conflict_cnt}, 32'h3);
`endif

    // Backpressure, then a refused push into a full FIFO that pops the same cycle.
    do_reset();
    out1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_data = 4'(i + 1); a_dest = 1'b0;
      step();
    end
    check("bp_full", {31'h0, a_ready}, 32'h0);
    check("bp_nov",  {31'h0, out1_valid}, 32'h0);
    a_data = 4'hF;
    out1_ready = 1'b1;
    step();
    idle_in();
    check("full_rdy", {31'h0, a_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), {27'h0, out1_valid, w_out1}, 32'h10 | (i + 1));
      step();
    end
    check("drain_end", {31'h0, out1_valid}, 32'h0);

`ifdef XBAR_SCHED_STATS_EN
    do_reset();
    a_valid = 1'b1; a_data = 4'h6; a_dest = 1'b0;
    b_valid = 1'b1; b_data = 4'h8; b_dest = 1'b0;
    for (int i = 0; i < 65600; i++) step();
    idle_in();
    check("sat_cnt", {16'h0, conflict_cnt}, 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
